// File: rtl/axi_bus_splitter.sv
// rtl/axi_bus_splitter.sv - single-beat AXI4-Lite 1-to-2 address router
// Independent write/read FSMs; one outstanding transaction per direction.
module axi_bus_splitter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = 32'hF000_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   M_awaddr,
  input  logic                    M_awvalid,
  output logic                    M_awready,
  input  logic [DATA_WIDTH-1:0]   M_wdata,
  input  logic [DATA_WIDTH/8-1:0] M_wstrb,
  input  logic                    M_wvalid,
  output logic                    M_wready,
  output logic [1:0]              M_bresp,
  output logic                    M_bvalid,
  input  logic                    M_bready,
  input  logic [ADDR_WIDTH-1:0]   M_araddr,
  input  logic                    M_arvalid,
  output logic                    M_arready,
  output logic [DATA_WIDTH-1:0]   M_rdata,
  output logic [1:0]              M_rresp,
  output logic                    M_rvalid,
  output logic                    M_rlast,
  input  logic                    M_rready,
  output logic [ADDR_WIDTH-1:0]   S0_awaddr,
  output logic                    S0_awvalid,
  input  logic                    S0_awready,
  output logic [DATA_WIDTH-1:0]   S0_wdata,
  output logic [DATA_WIDTH/8-1:0] S0_wstrb,
  output logic                    S0_wvalid,
  input  logic                    S0_wready,
  input  logic [1:0]              S0_bresp,
  input  logic                    S0_bvalid,
  output logic                    S0_bready,
  output logic [ADDR_WIDTH-1:0]   S0_araddr,
  output logic                    S0_arvalid,
  input  logic                    S0_arready,
  input  logic [DATA_WIDTH-1:0]   S0_rdata,
  input  logic [1:0]              S0_rresp,
  input  logic                    S0_rvalid,
  output logic                    S0_rready,
  output logic [ADDR_WIDTH-1:0]   S1_awaddr,
  output logic                    S1_awvalid,
  input  logic                    S1_awready,
  output logic [DATA_WIDTH-1:0]   S1_wdata,
  output logic [DATA_WIDTH/8-1:0] S1_wstrb,
  output logic                    S1_wvalid,
  input  logic                    S1_wready,
  input  logic [1:0]              S1_bresp,
  input  logic                    S1_bvalid,
  output logic                    S1_bready,
  output logic [ADDR_WIDTH-1:0]   S1_araddr,
  output logic                    S1_arvalid,
  input  logic                    S1_arready,
  input  logic [DATA_WIDTH-1:0]   S1_rdata,
  input  logic [1:0]              S1_rresp,
  input  logic                    S1_rvalid,
  output logic                    S1_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_BACK} r_state_t;

  w_state_t              r_wstate;
  logic                  r_aw_cap;
  logic                  r_w_cap;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_wsel;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [1:0]            r_bresp;
  logic                  r_bvalid;

  r_state_t              r_rstate;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_rsel;
  logic                  r_arvalid;
  logic                  r_rready;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid;

  logic w_awready;
  logic w_wready;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_sel;
  logic w_ar_sel;
  logic w_sel_awready;
  logic w_sel_wready;
  logic w_sel_bvalid;
  logic w_sel_arready;
  logic w_sel_rvalid;

  // A select bit of 1 routes to S1, 0 to S0.
  assign w_aw_sel = ((M_awaddr & S1_MASK) == S1_BASE);
  assign w_ar_sel = ((M_araddr & S1_MASK) == S1_BASE);

  assign w_awready = (r_wstate == W_IDLE) && !r_aw_cap;
  assign w_wready  = (r_wstate == W_IDLE) && !r_w_cap;
  assign w_aw_hs   = M_awvalid && w_awready;
  assign w_w_hs    = M_wvalid && w_wready;

  assign w_sel_awready = r_wsel ? S1_awready : S0_awready;
  assign w_sel_wready  = r_wsel ? S1_wready  : S0_wready;
  assign w_sel_bvalid  = r_wsel ? S1_bvalid  : S0_bvalid;
  assign w_sel_arready = r_rsel ? S1_arready : S0_arready;
  assign w_sel_rvalid  = r_rsel ? S1_rvalid  : S0_rvalid;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wsel    <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_bresp   <= 2'b00;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr <= M_awaddr;
            r_wsel   <= w_aw_sel;
            r_aw_cap <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata <= M_wdata;
            r_wstrb <= M_wstrb;
            r_w_cap <= 1'b1;
          end
          if ((r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs)) begin
            r_wstate  <= W_FWD;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        W_FWD: begin
          if (w_sel_awready) r_awvalid <= 1'b0;
          if (w_sel_wready)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || w_sel_awready) && (!r_wvalid || w_sel_wready)) begin
            r_wstate <= W_RESP;
            r_bready <= 1'b1;
          end
        end
        W_RESP: begin
          if (w_sel_bvalid) begin
            r_bresp  <= r_wsel ? S1_bresp : S0_bresp;
            r_bready <= 1'b0;
            r_bvalid <= 1'b1;
            r_wstate <= W_BACK;
          end
        end
        W_BACK: begin
          if (M_bready) begin
            r_bvalid <= 1'b0;
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_rsel    <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rvalid  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (M_arvalid) begin
            r_araddr  <= M_araddr;
            r_rsel    <= w_ar_sel;
            r_arvalid <= 1'b1;
            r_rstate  <= R_FWD;
          end
        end
        R_FWD: begin
          if (w_sel_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (w_sel_rvalid) begin
            r_rdata  <= r_rsel ? S1_rdata : S0_rdata;
            r_rresp  <= r_rsel ? S1_rresp : S0_rresp;
            r_rready <= 1'b0;
            r_rvalid <= 1'b1;
            r_rstate <= R_BACK;
          end
        end
        R_BACK: begin
          if (M_rready) begin
            r_rvalid <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign M_awready = w_awready;
  assign M_wready  = w_wready;
  assign M_bresp   = r_bresp;
  assign M_bvalid  = r_bvalid;
  assign M_arready = (r_rstate == R_IDLE);
  assign M_rdata   = r_rdata;
  assign M_rresp   = r_rresp;
  assign M_rvalid  = r_rvalid;
  assign M_rlast   = 1'b1;

  // Payload fans out to both slaves; only the handshakes are steered.
  assign S0_awaddr  = r_awaddr;
  assign S1_awaddr  = r_awaddr;
  assign S0_wdata   = r_wdata;
  assign S1_wdata   = r_wdata;
  assign S0_wstrb   = r_wstrb;
  assign S1_wstrb   = r_wstrb;
  assign S0_araddr  = r_araddr;
  assign S1_araddr  = r_araddr;

  assign S0_awvalid = r_awvalid && !r_wsel;
  assign S1_awvalid = r_awvalid &&  r_wsel;
  assign S0_wvalid  = r_wvalid  && !r_wsel;
  assign S1_wvalid  = r_wvalid  &&  r_wsel;
  assign S0_bready  = r_bready  && !r_wsel;
  assign S1_bready  = r_bready  &&  r_wsel;
  assign S0_arvalid = r_arvalid && !r_rsel;
  assign S1_arvalid = r_arvalid &&  r_rsel;
  assign S0_rready  = r_rready  && !r_rsel;
  assign S1_rready  = r_rready  &&  r_rsel;

endmodule
